// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared L1 cache constants and types: geometry of the 4-way, 8192-set L1,
// line address / one-hot way types, the victim sequencer state encoding and
// a one-hot legality helper used on the replacement logic's victim select.
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int SET_W = 13;
    localparam int TAG_W = 14;
    localparam int WAYS  = 4;

    typedef logic [TAG_W+SET_W-1:0] line_addr_t;
    typedef logic [WAYS-1:0]        way_oh_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_WB_REQ    = 3'd2,
        ST_WB_WAIT   = 3'd3,
        ST_FILL_REQ  = 3'd4,
        ST_FILL_WAIT = 3'd5,
        ST_UPDATE    = 3'd6
    } evict_state_e;

    // True when exactly one bit of the way select is set: non-zero and
    // clearing the lowest set bit leaves nothing behind.
    function automatic logic onehot_ok(input way_oh_t v);
        return (v != '0) && ((v & (v - way_oh_t'(1'b1))) == '0);
    endfunction

endpackage

// File: rtl/evt_ctr.sv
// -----------------------------------------------------------------------------
// evt_ctr
// 32-bit event counter, increments by one per cycle with inc high and wraps
// naturally at 2^32.
//   clk   : clock
//   reset : synchronous, active-high; clears the count
//   inc   : count this cycle
//   count : current count (registered)
// -----------------------------------------------------------------------------
module evt_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: step on inc, otherwise hold.
    always_comb begin
        if (inc) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/evict_ctl.sv
// -----------------------------------------------------------------------------
// evict_ctl
// Miss-side victim sequencer for the 4-way L1. Captures a miss, reads the
// dirty bits of the missing set, issues a writeback of the victim way when it
// is dirty, then a line fill, then rewrites the victim way's dirty bit.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   miss_valid / miss_ready    : miss request handshake (ready only in IDLE)
//   miss_set/tag/victim_tag    : miss set, missing tag, tag held in victim way
//   miss_victim, miss_store    : one-hot victim way, store-miss flag
//   dirty_ra / dirty_rd        : dirty regfile read port (rd combinational)
//   dirty_wr/wa/way/in         : dirty regfile write port
//   wb_valid/ready/addr/way    : writeback request handshake
//   wb_done                    : writeback drained pulse
//   fill_valid/ready/addr      : fill request handshake
//   fill_done                  : fill completed pulse
//   busy                       : sequencer active (hit path stalls)
//   miss_done / miss_err       : miss retired / illegal victim pulses
//   wb_count / miss_count      : wrapping event counters
// -----------------------------------------------------------------------------
module evict_ctl #(
    parameter int SET_W = cache_pkg::SET_W,
    parameter int TAG_W = cache_pkg::TAG_W,
    parameter int WAYS  = cache_pkg::WAYS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [SET_W-1:0]       miss_set,
    input  logic [TAG_W-1:0]       miss_tag,
    input  logic [TAG_W-1:0]       miss_victim_tag,
    input  logic [WAYS-1:0]        miss_victim,
    input  logic                   miss_store,
    output logic [SET_W-1:0]       dirty_ra,
    input  logic [WAYS-1:0]        dirty_rd,
    output logic                   dirty_wr,
    output logic [SET_W-1:0]       dirty_wa,
    output logic [WAYS-1:0]        dirty_way,
    output logic                   dirty_in,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [TAG_W+SET_W-1:0] wb_addr,
    output logic [WAYS-1:0]        wb_way,
    input  logic                   wb_done,
    output logic                   fill_valid,
    input  logic                   fill_ready,
    output logic [TAG_W+SET_W-1:0] fill_addr,
    input  logic                   fill_done,
    output logic                   busy,
    output logic                   miss_done,
    output logic                   miss_err,
    output logic [31:0]            wb_count,
    output logic [31:0]            miss_count
);

    import cache_pkg::*;

    evict_state_e     state_q, state_d;

    // Captured miss request; every downstream address comes from these.
    logic [SET_W-1:0] set_q, set_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] vtag_q, vtag_d;
    logic [WAYS-1:0]  victim_q, victim_d;
    logic             store_q, store_d;

    // Registered control outputs.
    logic             miss_ready_q, miss_ready_d;
    logic             busy_q, busy_d;
    logic             wb_valid_q, wb_valid_d;
    logic             fill_valid_q, fill_valid_d;
    logic             dirty_wr_q, dirty_wr_d;
    logic             miss_done_q, miss_done_d;
    logic             miss_err_q, miss_err_d;

    logic             wb_fire_s;
    logic             retire_s;

    // Next-state, capture and registered-output logic. Outputs are derived
    // from the next state so they line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        tag_d      = tag_q;
        vtag_d     = vtag_q;
        victim_d   = victim_q;
        store_d    = store_q;
        miss_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (miss_valid && miss_ready_q) begin
                    set_d    = miss_set;
                    tag_d    = miss_tag;
                    vtag_d   = miss_victim_tag;
                    victim_d = miss_victim;
                    store_d  = miss_store;
                    state_d  = ST_CHECK;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // dirty_rd here is the read of set_q issued this cycle.
                if (!onehot_ok(victim_q)) begin
                    miss_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if ((dirty_rd & victim_q) != '0) begin
                    state_d    = ST_WB_REQ;
                end else begin
                    state_d    = ST_FILL_REQ;
                end
            end
            ST_WB_REQ: begin
                if (wb_ready) begin
                    state_d = ST_WB_WAIT;
                end else begin
                    state_d = ST_WB_REQ;
                end
            end
            ST_WB_WAIT: begin
                if (wb_done) begin
                    state_d = ST_FILL_REQ;
                end else begin
                    state_d = ST_WB_WAIT;
                end
            end
            ST_FILL_REQ: begin
                if (fill_ready) begin
                    state_d = ST_FILL_WAIT;
                end else begin
                    state_d = ST_FILL_REQ;
                end
            end
            ST_FILL_WAIT: begin
                if (fill_done) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_FILL_WAIT;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        miss_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        wb_valid_d   = (state_d == ST_WB_REQ);
        fill_valid_d = (state_d == ST_FILL_REQ);
        dirty_wr_d   = (state_d == ST_UPDATE);
        miss_done_d  = (state_d == ST_UPDATE);
    end

    // State, captured request and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            set_q        <= '0;
            tag_q        <= '0;
            vtag_q       <= '0;
            victim_q     <= '0;
            store_q      <= 1'b0;
            miss_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            fill_valid_q <= 1'b0;
            dirty_wr_q   <= 1'b0;
            miss_done_q  <= 1'b0;
            miss_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            tag_q        <= tag_d;
            vtag_q       <= vtag_d;
            victim_q     <= victim_d;
            store_q      <= store_d;
            miss_ready_q <= miss_ready_d;
            busy_q       <= busy_d;
            wb_valid_q   <= wb_valid_d;
            fill_valid_q <= fill_valid_d;
            dirty_wr_q   <= dirty_wr_d;
            miss_done_q  <= miss_done_d;
            miss_err_q   <= miss_err_d;
        end
    end

    // A writeback is counted when the request is accepted, a miss when it
    // leaves UPDATE (the cycle miss_done is high).
    assign wb_fire_s = (state_q == ST_WB_REQ) && wb_ready;
    assign retire_s  = (state_q == ST_UPDATE);

    evt_ctr u_wb_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (wb_fire_s),
        .count (wb_count)
    );

    evt_ctr u_miss_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (retire_s),
        .count (miss_count)
    );

    // All addresses come from captured registers, so there is no
    // combinational path from the miss request into the regfile or memory.
    assign miss_ready = miss_ready_q;
    assign busy       = busy_q;
    assign dirty_ra   = set_q;
    assign dirty_wr   = dirty_wr_q;
    assign dirty_wa   = set_q;
    assign dirty_way  = victim_q;
    assign dirty_in   = store_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = {vtag_q, set_q};
    assign wb_way     = victim_q;
    assign fill_valid = fill_valid_q;
    assign fill_addr  = {tag_q, set_q};
    assign miss_done  = miss_done_q;
    assign miss_err   = miss_err_q;

endmodule

// File: tb/tb_evict_ctl.sv
// -----------------------------------------------------------------------------
// tb_evict_ctl
// Self-checking bench for evict_ctl. A behavioural dirty regfile answers the
// read port and takes the write port; the bench also plays the writeback/fill
// engine with random backpressure and completion delays. Expected behaviour
// per miss is derived from the miss rules (writeback iff the legal victim way
// is dirty, victim dirty bit becomes the store flag) against a shadow copy of
// the dirty state and shadow counters.
// -----------------------------------------------------------------------------
module tb_evict_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic [12:0] miss_set;
    logic [13:0] miss_tag;
    logic [13:0] miss_victim_tag;
    logic [3:0]  miss_victim;
    logic        miss_store;
    logic [12:0] dirty_ra;
    logic [3:0]  dirty_rd;
    logic        dirty_wr;
    logic [12:0] dirty_wa;
    logic [3:0]  dirty_way;
    logic        dirty_in;
    logic        wb_valid;
    logic        wb_ready;
    logic [26:0] wb_addr;
    logic [3:0]  wb_way;
    logic        wb_done;
    logic        fill_valid;
    logic        fill_ready;
    logic [26:0] fill_addr;
    logic        fill_done;
    logic        busy;
    logic        miss_done;
    logic        miss_err;
    logic [31:0] wb_count;
    logic [31:0] miss_count;

    // Behavioural dirty regfile and preload port.
    logic [3:0]  dmem [0:8191];
    logic        pre_we;
    logic [12:0] pre_a;
    logic [3:0]  pre_d;

    // Reference model state.
    logic [3:0]  model_dirty [0:8191];
    logic [31:0] model_wb;
    logic [31:0] model_miss;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    evict_ctl dut (
        .clk             (clk),
        .reset           (reset),
        .miss_valid      (miss_valid),
        .miss_ready      (miss_ready),
        .miss_set        (miss_set),
        .miss_tag        (miss_tag),
        .miss_victim_tag (miss_victim_tag),
        .miss_victim     (miss_victim),
        .miss_store      (miss_store),
        .dirty_ra        (dirty_ra),
        .dirty_rd        (dirty_rd),
        .dirty_wr        (dirty_wr),
        .dirty_wa        (dirty_wa),
        .dirty_way       (dirty_way),
        .dirty_in        (dirty_in),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_addr         (wb_addr),
        .wb_way          (wb_way),
        .wb_done         (wb_done),
        .fill_valid      (fill_valid),
        .fill_ready      (fill_ready),
        .fill_addr       (fill_addr),
        .fill_done       (fill_done),
        .busy            (busy),
        .miss_done       (miss_done),
        .miss_err        (miss_err),
        .wb_count        (wb_count),
        .miss_count      (miss_count)
    );

    assign dirty_rd = dmem[dirty_ra];

    // Regfile write: bench preload has priority over the DUT write port.
    always @(posedge clk) begin
        if (pre_we) begin
            dmem[pre_a] <= pre_d;
        end else if (dirty_wr) begin
            dmem[dirty_wa] <= (dmem[dirty_wa] & ~dirty_way) | (dirty_in ? dirty_way : 4'b0000);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write one regfile entry and its shadow copy (DUT must be idle).
    task automatic preload(input logic [12:0] a, input logic [3:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
        model_dirty[a] = d;
    endtask

    // Idle cycles with stray completion pulses; the DUT must stay idle.
    task automatic idle_strays(input int n);
        for (int i = 0; i < n; i++) begin
            wb_done   = 1'($urandom_range(1, 0));
            fill_done = 1'($urandom_range(1, 0));
            @(negedge clk);
            wb_done   = 1'b0;
            fill_done = 1'b0;
            chk("idle_busy", busy, 1'b0);
            chk("idle_ready", miss_ready, 1'b1);
        end
    endtask

    // One complete miss transaction, checked against the rule-level model.
    // hold: cycles each request is refused (with stray done pulses) first.
    task automatic run_miss(input logic [12:0] s, input logic [13:0] t, input logic [13:0] vt,
                            input logic [3:0] v, input logic st, input int hold);
        logic legal, exp_wb;
        bit   seen_wb, seen_fill, seen_wr, seen_err, ended;
        int   cyc, wait_n, wb_phase, wb_dly, wb_fin, fill_phase, fill_dly, fill_fin;
        int   wb_hold, fill_hold;

        legal  = ($countones(v) == 1);
        exp_wb = legal && ((model_dirty[s] & v) != 4'b0000);

        wait_n = 0;
        while (!miss_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("accept_ready", miss_ready, 1'b1);

        miss_valid      = 1'b1;
        miss_set        = s;
        miss_tag        = t;
        miss_victim_tag = vt;
        miss_victim     = v;
        miss_store      = st;
        @(negedge clk);
        // Scramble request fields so any late sampling shows up.
        miss_valid      = 1'b0;
        miss_set        = 13'($urandom);
        miss_tag        = 14'($urandom);
        miss_victim_tag = 14'($urandom);
        miss_victim     = 4'($urandom);
        miss_store      = 1'($urandom);

        seen_wb = 0; seen_fill = 0; seen_wr = 0; seen_err = 0; ended = 0;
        wb_phase = 0; wb_dly = 0; wb_fin = -100; fill_phase = 0; fill_dly = 0; fill_fin = -100;
        wb_hold = hold; fill_hold = hold;
        cyc = 1;
        while (!ended && cyc < 200) begin
            wb_done = 1'b0; fill_done = 1'b0; wb_ready = 1'b0; fill_ready = 1'b0;
            if (cyc == 1) begin
                chk("check_busy", busy, 1'b1);
                chk("check_ra", dirty_ra, s);
            end
            if (cyc == 2) begin
                if (!legal)      chk("err_latency", miss_err, 1'b1);
                else if (exp_wb) chk("wb_latency", wb_valid, 1'b1);
                else             chk("fill_latency", fill_valid, 1'b1);
            end
            if (wb_phase == 1) begin
                if (wb_dly == 0) begin wb_done = 1'b1; wb_phase = 2; wb_fin = cyc; end
                else wb_dly--;
            end
            if (fill_phase == 1) begin
                if (fill_dly == 0) begin fill_done = 1'b1; fill_phase = 2; fill_fin = cyc; end
                else fill_dly--;
            end
            if (wb_valid) begin
                if (!seen_wb) chk("wb_expected", exp_wb, 1'b1);
                seen_wb = 1;
                chk("wb_addr", wb_addr, {vt, s});
                chk("wb_way", wb_way, v);
                if (wb_hold > 0) begin
                    wb_hold--; wb_done = 1'b1; fill_done = 1'b1;
                end else if ($urandom_range(1, 0) == 1) begin
                    wb_ready = 1'b1; wb_phase = 1; wb_dly = $urandom_range(3, 0);
                end
            end
            if (fill_valid) begin
                if (!seen_fill) begin
                    chk("fill_legal", legal, 1'b1);
                    if (exp_wb) chk("fill_after_wb", cyc, wb_fin + 1);
                end
                seen_fill = 1;
                chk("fill_addr", fill_addr, {t, s});
                if (fill_hold > 0) begin
                    fill_hold--; wb_done = 1'b1; fill_done = 1'b1;
                end else if ($urandom_range(1, 0) == 1) begin
                    fill_ready = 1'b1; fill_phase = 1; fill_dly = $urandom_range(3, 0);
                end
            end
            if (dirty_wr) begin
                seen_wr = 1;
                chk("dirty_wa", dirty_wa, s);
                chk("dirty_way", dirty_way, v);
                chk("dirty_in", dirty_in, st);
            end
            if (miss_done) begin
                chk("done_after_fill", cyc, fill_fin + 1);
                chk("done_with_wr", dirty_wr, 1'b1);
                ended = 1;
            end
            if (miss_err) begin
                seen_err = 1;
                chk("err_ready", miss_ready, 1'b1);
                ended = 1;
            end
            @(negedge clk);
            cyc++;
        end
        wb_done = 1'b0; fill_done = 1'b0; wb_ready = 1'b0; fill_ready = 1'b0;
        if (!ended) chk("miss_timeout", 1'b0, 1'b1);

        chk("saw_wb", seen_wb, exp_wb);
        chk("saw_fill", seen_fill, legal);
        chk("saw_dirty_wr", seen_wr, legal);
        chk("saw_err", seen_err, !legal);

        if (legal) begin
            model_dirty[s] = (model_dirty[s] & ~v) | (st ? v : 4'b0000);
            model_miss++;
            if (exp_wb) model_wb++;
        end
        chk("wb_count", wb_count, model_wb);
        chk("miss_count", miss_count, model_miss);
        chk("regfile", dmem[s], model_dirty[s]);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic [3:0] v;
        int n;

        reset = 1'b1; miss_valid = 1'b0; miss_set = '0; miss_tag = '0; miss_victim_tag = '0;
        miss_victim = '0; miss_store = 1'b0; wb_ready = 1'b0; wb_done = 1'b0;
        fill_ready = 1'b0; fill_done = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
        model_wb = 32'd0; model_miss = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", miss_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valids", {wb_valid, fill_valid, dirty_wr}, 3'b000);
        chk("rst_pulses", {miss_done, miss_err}, 2'b00);
        chk("rst_wb_count", wb_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        chk("rst_ra", dirty_ra, 13'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) preload(13'(i), 4'($urandom));
        preload(13'h0A5, 4'b0010);
        preload(13'h1FFF, 4'b1000);
        preload(13'h0010, 4'b0010);

        idle_strays(3);

        // Clean victim, refused fill with stray pulses in FILL_REQ.
        run_miss(13'h0A5, 14'h2ABC, 14'h0F0F, 4'b0001, 1'b0, 2);
        // Dirty victim, writeback refused for 3 cycles, store miss.
        run_miss(13'h1FFF, 14'h3001, 14'h1234, 4'b1000, 1'b1, 3);
        // Illegal victim select.
        run_miss(13'h0002, 14'h0111, 14'h0222, 4'b0110, 1'b0, 0);
        idle_strays(2);

        // Reset while waiting for writeback data to drain.
        miss_valid = 1'b1; miss_set = 13'h0010; miss_tag = 14'h0033; miss_victim_tag = 14'h0044;
        miss_victim = 4'b0010; miss_store = 1'b0;
        @(negedge clk);
        miss_valid = 1'b0;
        n = 0;
        while (!wb_valid && n < 10) begin @(negedge clk); n++; end
        chk("rst_mid_wb_valid", wb_valid, 1'b1);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("rst_mid_busy_pre", busy, 1'b1);
        chk("rst_mid_wb_count_pre", wb_count, model_wb + 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_wb = 32'd0; model_miss = 32'd0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ready", miss_ready, 1'b1);
        chk("rst_mid_wb_count", wb_count, model_wb);
        chk("rst_mid_miss_count", miss_count, model_miss);
        chk("rst_mid_wb_valid_low", wb_valid, 1'b0);
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
        chk("late_wb_done_busy", busy, 1'b0);
        chk("late_wb_done_fill", fill_valid, 1'b0);
        idle_strays(1);

        // Writeback counter wrap.
        preload(13'h0003, 4'b0100);
        force dut.u_wb_ctr.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_wb_ctr.cnt_q;
        chk("wrap_preload", wb_count, 32'hFFFF_FFFF);
        model_wb = 32'hFFFF_FFFF;
        @(negedge clk);
        run_miss(13'h0003, 14'h1111, 14'h2222, 4'b0100, 1'b0, 0);
        chk("wrap_zero", wb_count, 32'd0);

        // Randomised misses over a few sets so dirty state carries over.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(7, 0) == 0) begin
                case ($urandom_range(4, 0))
                    0:       v = 4'b0000;
                    1:       v = 4'b0011;
                    2:       v = 4'b0110;
                    3:       v = 4'b1111;
                    default: v = 4'b1010;
                endcase
            end else begin
                v = 4'b0001 << $urandom_range(3, 0);
            end
            run_miss(13'($urandom_range(7, 0)), 14'($urandom), 14'($urandom), v,
                     1'($urandom), $urandom_range(2, 0));
            idle_strays($urandom_range(2, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/evict_ctl.md
Name: evict_ctl

Overview:
- Miss-side victim sequencer for the 4-way, 8192-set L1.
- Sits directly downstream of the per-set dirty-bit regfile: it reads the 4 dirty bits of the missing set and decides whether the chosen victim way needs a writeback.
- Sequences writeback, then line fill, then writes the victim way's new dirty bit back into the regfile.
- Control only; the data movement engine lives elsewhere and is driven by the wb/fill handshakes.

Parameters:
- SET_W, 13, set index width (8192 sets)
- TAG_W, 14, tag width; line address = {tag, set}
- WAYS, 4, associativity; fixed, victim select is one-hot of this width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- miss_valid  in  1  miss request valid
- miss_ready  out  1  high only in IDLE
- miss_set  in  SET_W  set index of the miss
- miss_tag  in  TAG_W  tag of the missing line
- miss_victim_tag  in  TAG_W  tag currently held in the victim way
- miss_victim  in  WAYS  one-hot victim way from replacement logic
- miss_store  in  1  miss caused by a store (write-allocate marks line dirty)
- dirty_ra  out  SET_W  dirty regfile read address
- dirty_rd  in  WAYS  dirty regfile read data, combinational from dirty_ra
- dirty_wr  out  1  dirty regfile write enable
- dirty_wa  out  SET_W  dirty regfile write address
- dirty_way  out  WAYS  one-hot way select for the dirty write
- dirty_in  out  1  dirty value to write
- wb_valid  out  1  writeback request
- wb_ready  in  1  writeback request accepted
- wb_addr  out  TAG_W+SET_W  victim line address {victim_tag, set}
- wb_way  out  WAYS  victim way to read data from
- wb_done  in  1  single-cycle pulse: writeback data fully drained
- fill_valid  out  1  fill request
- fill_ready  in  1  fill request accepted
- fill_addr  out  TAG_W+SET_W  {miss_tag, set}
- fill_done  in  1  single-cycle pulse: line written into the data/tag arrays
- busy  out  1  high in any state except IDLE; hit path stalls and must not write the dirty regfile while high
- miss_done  out  1  single-cycle pulse, miss retired
- miss_err  out  1  single-cycle pulse, illegal victim select
- wb_count  out  32  writebacks issued; wraps at 2^32
- miss_count  out  32  misses retired (miss_done pulses); wraps at 2^32

Behaviour:
- Reset: state IDLE, busy=0, miss_ready=1, all valid, wr and pulse outputs 0, both counters 0, captured request registers 0.
- Reset mid-operation: immediate return to IDLE. Outstanding wb/fill transactions are abandoned; the memory side is reset together.
- States: IDLE, CHECK, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, UPDATE.
- IDLE: on miss_valid&&miss_ready, capture set, tag, victim_tag, victim and store; go to CHECK.
- CHECK (exactly 1 cycle): dirty_ra = captured set.
  - If popcount(victim) != 1: pulse miss_err next cycle and return to IDLE. No dirty write, no counter change.
  - Else if (dirty_rd & victim) != 0: go to WB_REQ.
  - Else: go to FILL_REQ.
- WB_REQ: wb_valid=1; wb_addr and wb_way held stable until wb_ready. On wb_valid&&wb_ready, wb_count+1 and go to WB_WAIT.
- WB_WAIT: wait for wb_done, then go to FILL_REQ. A wb_done outside WB_WAIT is ignored.
- FILL_REQ: fill_valid=1 with stable fill_addr until fill_ready, then go to FILL_WAIT.
- FILL_WAIT: wait for fill_done, then go to UPDATE. A fill_done outside FILL_WAIT is ignored.
- UPDATE (1 cycle): dirty_wr=1, dirty_wa=set, dirty_way=victim, dirty_in=store.
  - The victim way is always written, clearing it when the line is clean, so stale dirty state is never inherited.
  - miss_done pulses in the same cycle; miss_count+1; next state IDLE.
- Outside UPDATE: dirty_wr=0; dirty_wa/dirty_way driven from captured registers (don't-care).
- dirty_ra is driven from the captured set in every state, never from miss_set directly, so there is no combinational miss_set-to-dirty_ra path.
- Latency, no backpressure:
  - Clean victim: accept at cycle 0, CHECK 1, fill_valid 2, UPDATE and miss_done 1 cycle after fill_done.
  - Dirty victim: wb_valid at cycle 2.
- Back-to-back misses: miss_ready returns the cycle after UPDATE; minimum miss-to-miss spacing is 5 cycles.

Decomposition:
- Shared package cache_pkg:
  - SET_W, TAG_W, WAYS constants
  - line_addr_t = logic[TAG_W+SET_W-1:0]
  - way_oh_t = logic[WAYS-1:0]
  - evict_state_e enum
  - onehot_ok() function
- No sub-module needed. Optionally factor a 32-bit wrapping event counter as evt_ctr, instanced twice.

Test Plan:
- Clean victim: dirty_rd=4'b0010, victim=4'b0001, set=13'h0A5, store=0 -> no wb_valid; fill_addr={tag,13'h0A5}; UPDATE writes way0 dirty_in=0; miss_done; miss_count=1, wb_count=0.
- Dirty victim, wb_ready held low 3 cycles: dirty_rd=4'b1000, victim=4'b1000, victim_tag=14'h1234, set=13'h1FFF -> wb_addr={14'h1234,13'h1FFF} stable for 3 cycles; wb_count=1 after the handshake; fill issues only after wb_done; store=1 -> dirty_in=1, dirty_way=4'b1000.
- Illegal victim: victim=4'b0110 -> miss_err pulse 2 cycles after accept; no wb/fill/dirty_wr; counters unchanged; miss_ready=1 next cycle.
- Reset asserted during WB_WAIT -> next cycle IDLE, busy=0, counters 0; a late wb_done pulse is ignored.
- Stray wb_done/fill_done pulses in IDLE and FILL_REQ -> no state change.
- Counter wrap: preload wb_count=32'hFFFF_FFFF via force, complete a dirty miss -> wb_count=0.
